// File: rtl/cfg_dat_bus_arbiter_pkg.sv
// cfg_arb_pkg: shared definitions for the CFG_DAT bus arbiter.
// Contents: FSM state encoding, requester index constants, the "no owner" code and a
// 3-way majority vote used when the control registers are triplicated.
package cfg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam logic [1:0] REQ_BPI    = 2'd0;
  localparam logic [1:0] REQ_GBT    = 2'd1;
  localparam logic [1:0] REQ_LED    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'b11;

  // Width of the packed {state, owner, gnt} control word.
  localparam int CTL_W = 7;

  function automatic logic [CTL_W-1:0] vote3(input logic [CTL_W-1:0] a,
                                             input logic [CTL_W-1:0] b,
                                             input logic [CTL_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cfg_dat_bus_arbiter_if.sv
// cfg_dat_bus_if: requester-side bundle for the CFG_DAT bus arbiter.
// Requests/enables/drive data flow in (REQ, OE, DO0..DO2); grant, owner, status and the
// IOBUF controls flow out (GNT, OWNER, BUSY, TIMEOUT, DATA_OUT, DATA_T).
interface cfg_dat_bus_if;

  logic [2:0]  REQ;
  logic [2:0]  OE;
  logic [15:0] DO0;
  logic [15:0] DO1;
  logic [15:0] DO2;
  logic [2:0]  GNT;
  logic [1:0]  OWNER;
  logic        BUSY;
  logic        TIMEOUT;
  logic [15:0] DATA_OUT;
  logic [15:0] DATA_T;

  // Requester / top-level side.
  modport master (
    output REQ, OE, DO0, DO1, DO2,
    input  GNT, OWNER, BUSY, TIMEOUT, DATA_OUT, DATA_T
  );

  // Arbiter side.
  modport slave (
    input  REQ, OE, DO0, DO1, DO2,
    output GNT, OWNER, BUSY, TIMEOUT, DATA_OUT, DATA_T
  );

endinterface

// File: rtl/cfg_dat_bus_arbiter_fsm.sv
// cfg_arb_fsm: grant FSM for the CFG_DAT bus (IDLE -> GRANT -> TURN -> IDLE).
// Latency: grant registered on the first edge that sees an eligible REQ; no preemption.
// Hold: req 1/2 forced off after HOLD_MAX cycles (TIMEOUT pulse); req 0 never limited.
// Ports: clk, rst (async, active-high), req[2:0] in; gnt[2:0], owner, owner_nxt, busy,
// timeout out. owner_nxt is the owner the next edge will load, used for the data regs.
// Macro CFG_ARB_ROUND_ROBIN_EN: req 1/2 alternate when both pending (default: 0 > 1 > 2).
module cfg_arb_fsm
  import cfg_arb_pkg::*;
#(
  parameter int          TMR      = 0,
  parameter int          TURN_CYC = 2,
  parameter logic [15:0] HOLD_MAX = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] owner,
  output logic [1:0] owner_nxt,
  output logic       busy,
  output logic       timeout
);

  localparam logic [3:0]       TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [15:0]      HOLD_LAST = HOLD_MAX - 16'd1;
  localparam logic [CTL_W-1:0] CTL_RST   = {IDLE, OWNER_NONE, 3'b000};

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [2:0]       gnt_nxt;
  logic [15:0]      hold_cnt;
  logic [15:0]      hold_nxt;
  logic [3:0]       turn_cnt;
  logic [3:0]       turn_nxt;
  logic [2:0]       blocked;
  logic [2:0]       blk_nxt;
  logic             to_nxt;
  logic [2:0]       elig;
  logic [1:0]       win;
  logic             req_own;
  logic [CTL_W-1:0] ctl_d;
  logic [CTL_W-1:0] ctl_q;

`ifdef CFG_ARB_ROUND_ROBIN_EN
  logic led_last;       // 1 = req 2 owned the bus most recently
  logic led_last_nxt;
`endif

  // A requester cut off by timeout stays blocked until it drops REQ.
  assign elig    = req & ~blocked;
  assign req_own = |(req & gnt);

  always_comb begin
    win = REQ_LED;
    if (elig[0]) win = REQ_BPI;
`ifdef CFG_ARB_ROUND_ROBIN_EN
    else if (elig[1] && elig[2]) win = led_last ? REQ_GBT : REQ_LED;
`endif
    else if (elig[1]) win = REQ_GBT;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    blk_nxt   = blocked & req;
    to_nxt    = 1'b0;
`ifdef CFG_ARB_ROUND_ROBIN_EN
    led_last_nxt = led_last;
`endif
    case (state)
      IDLE: begin
        if (|elig) begin
          state_nxt = GRANT;
          owner_nxt = win;
          gnt_nxt   = 3'b001 << win;
          hold_nxt  = '0;
`ifdef CFG_ARB_ROUND_ROBIN_EN
          if (win == REQ_GBT) led_last_nxt = 1'b0;
          else if (win == REQ_LED) led_last_nxt = 1'b1;
`endif
        end
      end
      GRANT: begin
        if (hold_cnt != 16'hFFFF) hold_nxt = hold_cnt + 16'd1;
        // A release on the same edge as the limit is a normal release.
        if (!req_own ||
            (owner != REQ_BPI && HOLD_MAX != 16'd0 && hold_cnt == HOLD_LAST)) begin
          state_nxt = TURN;
          owner_nxt = OWNER_NONE;
          gnt_nxt   = 3'b000;
          turn_nxt  = '0;
          if (req_own) begin
            to_nxt  = 1'b1;
            blk_nxt = blk_nxt | gnt;
          end
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) state_nxt = IDLE;
        else turn_nxt = turn_cnt + 4'd1;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWNER_NONE;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  assign ctl_d = {state_nxt, owner_nxt, gnt_nxt};

  // Control word registers; with TMR each copy reloads from the voted value every cycle,
  // so a single upset is scrubbed on the following edge.
  generate
    if (TMR != 0) begin : g_tmr
      logic [CTL_W-1:0] ctl_r0;
      logic [CTL_W-1:0] ctl_r1;
      logic [CTL_W-1:0] ctl_r2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctl_r0 <= CTL_RST;
          ctl_r1 <= CTL_RST;
          ctl_r2 <= CTL_RST;
        end else begin
          ctl_r0 <= ctl_d;
          ctl_r1 <= ctl_d;
          ctl_r2 <= ctl_d;
        end
      end
      assign ctl_q = vote3(ctl_r0, ctl_r1, ctl_r2);
    end else begin : g_single
      logic [CTL_W-1:0] ctl_r0;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ctl_r0 <= CTL_RST;
        else     ctl_r0 <= ctl_d;
      end
      assign ctl_q = ctl_r0;
    end
  endgenerate

  assign state = arb_state_t'(ctl_q[6:5]);
  assign owner = ctl_q[4:3];
  assign gnt   = ctl_q[2:0];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      turn_cnt <= '0;
      blocked  <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      blocked  <= blk_nxt;
      timeout  <= to_nxt;
    end
  end

`ifdef CFG_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_last <= 1'b1;
    else     led_last <= led_last_nxt;
  end
`endif

endmodule

// File: rtl/cfg_dat_bus_arbiter.sv
// cfg_dat_bus_arbiter: time-shares the 16-bit CFG_DAT pins between BPI (0), GBT (1), LED (2).
// Latency: GNT one edge after REQ; DATA_OUT/DATA_T registered alongside GNT, tristate on release.
// No preemption: later requests wait; TURN_CYC all-tristate cycles separate owners.
// Ports: CLK, RST (async, active-high) plus bus (cfg_dat_bus_if.slave): REQ/OE/DO0..DO2 in;
// GNT/OWNER/BUSY/TIMEOUT/DATA_OUT (IOBUF I)/DATA_T (IOBUF T, 1 = tristate) out.
// Macro CFG_ARB_ROUND_ROBIN_EN: round-robin between req 1 and 2 (req 0 keeps priority).
module cfg_dat_bus_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int          TMR      = 0,
  parameter int          TURN_CYC = 2,
  parameter logic [15:0] HOLD_MAX = 16'd50000
) (
  input logic          CLK,
  input logic          RST,
  cfg_dat_bus_if.slave bus
);

  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic [1:0]  owner_nxt;
  logic        busy;
  logic        timeout;
  logic [15:0] data_out_q;
  logic [15:0] data_t_q;

  cfg_arb_fsm #(
    .TMR      (TMR),
    .TURN_CYC (TURN_CYC),
    .HOLD_MAX (HOLD_MAX)
  ) u_fsm (
    .clk       (CLK),
    .rst       (RST),
    .req       (bus.REQ),
    .gnt       (gnt),
    .owner     (owner),
    .owner_nxt (owner_nxt),
    .busy      (busy),
    .timeout   (timeout)
  );

  // Pin registers follow the owner being loaded this edge, so the bus is driven in the
  // same cycle GNT rises and tristated in the same cycle GNT falls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_out_q <= '0;
      data_t_q   <= '1;
    end else begin
      case (owner_nxt)
        REQ_BPI: begin
          data_out_q <= bus.DO0;
          data_t_q   <= {16{~bus.OE[0]}};
        end
        REQ_GBT: begin
          data_out_q <= bus.DO1;
          data_t_q   <= {16{~bus.OE[1]}};
        end
        REQ_LED: begin
          data_out_q <= bus.DO2;
          data_t_q   <= {16{~bus.OE[2]}};
        end
        default: begin
          data_out_q <= '0;
          data_t_q   <= '1;
        end
      endcase
    end
  end

  assign bus.GNT      = gnt;
  assign bus.OWNER    = owner;
  assign bus.BUSY     = busy;
  assign bus.TIMEOUT  = timeout;
  assign bus.DATA_OUT = data_out_q;
  assign bus.DATA_T   = data_t_q;

endmodule
